// File: rtl/apb_csr_slave.sv
// APB CSR slave: operand and control registers feed a command FIFO, results are read back
// from a result FIFO, and STATUS reports FIFO flags plus a pending-command count.
module apb_csr_slave #(
    parameter int unsigned APB_BUS_SIZE   = 32,
    parameter int unsigned NUM_OPERANDS   = 2,
    parameter int unsigned OPERAND_WIDTH  = 12,
    parameter int unsigned OPERATION_SIZE = 2,
    parameter int unsigned FIFO_OUT_WIDTH = 25,
    parameter int unsigned RD_WAIT        = 1,
    parameter int unsigned PEND_W         = 4,
    localparam int unsigned AW = $clog2(NUM_OPERANDS + 3),
    localparam int unsigned CW = OPERATION_SIZE + NUM_OPERANDS * OPERAND_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AW-1:0]             addr,
    input  logic                      sel,
    input  logic                      en,
    input  logic                      write,
    input  logic [APB_BUS_SIZE-1:0]   wdata,
    output logic                      ready,
    output logic                      slv_err,
    output logic [APB_BUS_SIZE-1:0]   rdata,
    input  logic                      full_in,
    output logic                      w_en_in,
    output logic [CW-1:0]             w_data_in,
    input  logic                      empty_out,
    output logic                      r_en_out,
    input  logic [FIFO_OUT_WIDTH-1:0] final_result
);
    typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

    localparam int unsigned ResAddr    = NUM_OPERANDS + 1;
    localparam int unsigned StatusAddr = NUM_OPERANDS + 2;

    state_e                    r_state, w_state_next;
    logic [AW-1:0]             r_addr;
    logic                      r_write;
    logic [APB_BUS_SIZE-1:0]   r_wdata;
    logic                      r_err;
    logic [PEND_W+1:0]         r_status;
    logic [OPERAND_WIDTH-1:0]  r_operand [NUM_OPERANDS];
    logic [OPERATION_SIZE-1:0] r_op;
    logic [PEND_W-1:0]         r_pending;
    logic [2:0]                r_wcnt;
    logic [FIFO_OUT_WIDTH-1:0] r_res;

    logic                      w_setup, w_err, w_start, w_op_ok, w_opnd_we, w_op_we;
    logic [31:0]               w_addr32, w_raddr32;
    logic [OPERATION_SIZE-1:0] w_op;
    logic [FIFO_OUT_WIDTH-1:0] w_res;
    logic                      w_unused;

    assign w_addr32  = 32'(addr);
    assign w_raddr32 = 32'(r_addr);
    assign w_setup   = (r_state == StIdle) && sel && !en;
    assign w_op      = wdata[OPERATION_SIZE-1:0];
    assign w_start   = wdata[OPERATION_SIZE];
    assign w_op_ok   = (w_op == OPERATION_SIZE'(1)) || (w_op == OPERATION_SIZE'(2));
    assign w_unused  = ^{r_wdata, r_op};

    // Every error is decided from setup-phase inputs so the access phase has no side effects.
    always_comb begin
        w_err = 1'b1;
        if (w_addr32 == 32'd0) begin
            w_err = !write || (w_start && (full_in || !w_op_ok));
        end else if (w_addr32 <= NUM_OPERANDS) begin
            w_err = !write;
        end else if (w_addr32 == ResAddr) begin
            w_err = write || empty_out;
        end else if (w_addr32 == StatusAddr) begin
            w_err = write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_status  <= '0;
            r_op      <= '0;
            r_pending <= '0;
            r_wcnt    <= '0;
            r_res     <= '0;
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                r_operand[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_setup) begin
                r_addr   <= addr;
                r_write  <= write;
                r_wdata  <= wdata;
                r_err    <= w_err;
                r_status <= {r_pending, full_in, empty_out};
            end
            if (w_op_we) begin
                r_op <= r_wdata[OPERATION_SIZE-1:0];
            end
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (w_opnd_we && w_raddr32 == 32'(i + 1)) begin
                    r_operand[i] <= r_wdata[OPERAND_WIDTH-1:0];
                end
            end
            // r_wcnt holds the cycle index since the first ACCESS cycle while in WAIT.
            if (r_state == StAccess) begin
                r_wcnt <= 3'd1;
            end else if (r_state == StWait) begin
                r_wcnt <= r_wcnt + 3'd1;
            end
            if (r_state == StWait && r_wcnt == 3'd1) begin
                r_res <= final_result;
            end
            if (w_en_in && !r_en_out && r_pending != '1) begin
                r_pending <= r_pending + 1'b1;
            end else if (r_en_out && !w_en_in && r_pending != '0) begin
                r_pending <= r_pending - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        slv_err      = 1'b0;
        rdata        = '0;
        w_en_in      = 1'b0;
        r_en_out     = 1'b0;
        w_opnd_we    = 1'b0;
        w_op_we      = 1'b0;
        // The result FIFO output is only valid the cycle after the pop; later cycles use r_res.
        w_res        = (r_wcnt == 3'd1) ? final_result : r_res;
        unique case (r_state)
            StIdle: begin
                if (sel && !en) begin
                    w_state_next = StAccess;
                end
            end
            StAccess: begin
                w_state_next = StIdle;
                if (!sel) begin
                    w_state_next = StIdle;
                end else if (r_err) begin
                    ready   = 1'b1;
                    slv_err = 1'b1;
                end else if (w_raddr32 == ResAddr) begin
                    r_en_out     = 1'b1;
                    w_state_next = StWait;
                end else begin
                    ready = 1'b1;
                    if (w_raddr32 == StatusAddr) begin
                        rdata = APB_BUS_SIZE'(r_status);
                    end else if (w_raddr32 == 32'd0) begin
                        w_op_we = 1'b1;
                        w_en_in = r_wdata[OPERATION_SIZE];
                    end else begin
                        w_opnd_we = 1'b1;
                    end
                end
            end
            StWait: begin
                if (!sel) begin
                    w_state_next = StIdle;
                end else if (r_wcnt == 3'(RD_WAIT)) begin
                    ready        = 1'b1;
                    rdata        = APB_BUS_SIZE'(w_res);
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_data_in = '0;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            w_data_in[i*OPERAND_WIDTH +: OPERAND_WIDTH] = r_operand[i];
        end
        w_data_in[CW-1 -: OPERATION_SIZE] = r_wdata[OPERATION_SIZE-1:0];
    end

endmodule
